ode_record_loader: RTL and testbench
====================================

Name: ode_record_loader

Overview:
- Host-side producer for the collision-detect input memory.
- Accepts a stream of 32-bit words and packs every 8 consecutive words into one record.
- Presents each record on eight parallel buses and offers it with the rdyData/wein handshake: rdyData is a request, and the controller's wein is the acknowledge.
- Counts delivered records up to memory_depth, then reports load_done so the host can start the solve phase.

Parameters:
- memory_depth, 256: number of records to deliver before load_done.
- ACK_TIMEOUT, 1024: cycles to wait in OFFER for a wein rising edge before flagging ack_err.

Ports:
- clk  input  1  system clock, rising edge.
- rstmaster  input  1  asynchronous active-low reset.
- s_data  input  32  incoming word.
- s_valid  input  1  s_data valid.
- s_ready  output  1  loader accepts s_data this cycle.
- rdyData  output  1  record offered to the controller (request).
- wein  input  1  controller write enable (acknowledge).
- data0 .. data7  output  32 each  record word 0..7; data0 holds the first word received.
- record_count  output  9  records acknowledged so far.
- load_done  output  1  memory_depth records delivered; sticky.
- ack_err  output  1  ACK_TIMEOUT expired in OFFER; sticky.

Behaviour:
- Reset (rstmaster=0, asynchronous):
  - state=FILL, word index=0, data0..7=0, rdyData=0.
  - record_count=0, load_done=0, ack_err=0.
  - timeout counter=0, wein_q=0.
  - s_ready=0 during reset.
  - Reset mid-handshake drops rdyData immediately and discards the partial record.
- wein_q is wein registered every cycle. A rising edge is wein=1 and wein_q=0.
- FILL:
  - s_ready=1.
  - On s_valid and s_ready, data[idx] takes s_data and idx increments.
  - When the 8th word is accepted (idx=7), go to OFFER next cycle and reset idx to 0.
  - rdyData=0.
- OFFER:
  - rdyData=1, s_ready=0.
  - The timeout counter increments each cycle.
  - A wein level already high on entry is not an ack; only a rising edge counts.
  - On a rising edge: go to HOLD, rdyData=0 from the next cycle, clear the counter.
  - When the counter reaches ACK_TIMEOUT: set ack_err=1, stay in OFFER (rdyData stays 1), and keep counting saturated.
  - A later rising edge still completes the handshake; ack_err stays set.
- HOLD:
  - rdyData=0, s_ready=0.
  - data0..7 are held stable while wein=1, because the controller writes across several cycles.
  - When wein=0: record_count increments.
  - If the new count equals memory_depth, go to DONE; otherwise go to FILL.
- DONE:
  - load_done=1, s_ready=0, rdyData=0.
  - Remains here until rstmaster is asserted.
  - s_valid is ignored.
- Stability: data0..7 change only in FILL and are stable from the rdyData rise until wein falls.
- record_count width: the 9-bit counter is sized for the default memory_depth=256, the largest supported value. The count never wraps, because DONE is entered at equality.
- Latency: from the 8th accepted word to rdyData=1 is 1 cycle. From the wein fall to s_ready=1 is 1 cycle.
- Simultaneous events: s_valid during OFFER/HOLD/DONE is not accepted (s_ready=0); the source must hold the word.

Decomposition:
- Shared package ode_loader_pkg:
  - state enum {FILL, OFFER, HOLD, DONE};
  - RECORD_WORDS=8;
  - word width 32.
- One natural sub-module: ode_edge_ack, which registers wein and produces the rising-edge pulse and the low-level flag. It is reusable on the readback side.
- Everything else is inline.

Test Plan:
- Single record: stream 0x1..0x8 with s_valid held high -> data0=0x1 through data7=0x8; rdyData=1 one cycle after the 8th word; wein pulses high for 3 cycles -> rdyData=0 the cycle after the rise; record_count=1 the cycle after the wein fall; s_ready=1.
- Wein high before offer: hold wein=1 while the 8th word is accepted -> loader stays in OFFER (rdyData=1); drop then raise wein -> ack accepted; record_count=1.
- Back-pressure: s_valid asserted during HOLD with word 0xDEAD -> not accepted (s_ready=0); after the wein fall, 0xDEAD is latched into data0.
- Full load with memory_depth=4: 32 words and 4 handshakes -> load_done=1 and record_count=4 after the 4th wein fall; a 33rd word gets s_ready=0.
- Timeout with ACK_TIMEOUT=16: no wein after the offer -> ack_err=1 at cycle 16 with rdyData still 1; a later wein pulse -> record_count=1 and ack_err stays 1.
- Reset mid-OFFER: rstmaster low for 2 cycles -> rdyData=0 asynchronously; data0..7=0, record_count=0; after release, state=FILL and s_ready=1.

Source files
------------

// File: rtl/ode_loader_pkg.sv
// Shared types and constants for the collision-detect record loader.
// Holds the loader FSM state encoding and the record geometry.
package ode_loader_pkg;

    localparam int RECORD_WORDS = 8;
    localparam int WORD_W       = 32;
    localparam int IDX_W        = $clog2(RECORD_WORDS);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RECORD_WORDS - 1);

    typedef enum logic [1:0] {
        FILL,
        OFFER,
        HOLD,
        DONE
    } state_e;

endpackage

// File: rtl/ode_edge_ack.sv
// Registers the controller write enable and derives its rising-edge pulse
// and low-level flag. Ports: clk, rst_n, wein in; wein_q, rise, low out.
module ode_edge_ack (
    input  logic clk,
    input  logic rst_n,
    input  logic wein,
    output logic wein_q,
    output logic rise,
    output logic low
);

    logic wein_d;

    always_comb begin
        wein_d = wein;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wein_q <= 1'b0;
        end else begin
            wein_q <= wein_d;
        end
    end

    assign rise = wein & ~wein_q;
    assign low  = ~wein;

endmodule

// File: rtl/ode_record_loader.sv
// Packs 8 streamed words into a record and offers it with rdyData/wein.
// Ports: s_data/s_valid/s_ready in, data0..7/rdyData out, wein ack in,
// record_count, load_done and ack_err status out.
module ode_record_loader
    import ode_loader_pkg::*;
#(
    parameter int memory_depth = 256,
    parameter int ACK_TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rstmaster,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        rdyData,
    input  logic        wein,
    output logic [31:0] data0,
    output logic [31:0] data1,
    output logic [31:0] data2,
    output logic [31:0] data3,
    output logic [31:0] data4,
    output logic [31:0] data5,
    output logic [31:0] data6,
    output logic [31:0] data7,
    output logic [8:0]  record_count,
    output logic        load_done,
    output logic        ack_err
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(ACK_TIMEOUT);
    localparam logic [8:0] DEPTH = 9'(memory_depth);

    state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [RECORD_WORDS-1:0][WORD_W-1:0] data_q, data_d;
    logic [8:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic err_q, err_d;
    logic rdy_q, rdy_d;
    logic s_ready_q, s_ready_d;
    logic done_q, done_d;

    logic wein_q;
    logic ack_rise;
    logic wein_low;

    ode_edge_ack u_edge (
        .clk    (clk),
        .rst_n  (rstmaster),
        .wein   (wein),
        .wein_q (wein_q),
        .rise   (ack_rise),
        .low    (wein_low)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        unique case (state_q)
            FILL: begin
                if (s_valid && s_ready_q) begin
                    data_d[idx_q] = s_data;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = OFFER;
                        idx_d   = '0;
                    end
                end
            end
            OFFER: begin
                if (ack_rise) begin
                    state_d = HOLD;
                    tmo_d   = '0;
                end else begin
                    // Saturate so a late ack still completes cleanly.
                    if (tmo_q != TMO_MAX) begin
                        tmo_d = tmo_q + 1'b1;
                    end
                    if (tmo_d == TMO_MAX) begin
                        err_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                // Controller writes over several cycles; wait for wein low.
                if (wein_low) begin
                    cnt_d   = cnt_q + 9'd1;
                    state_d = (cnt_d == DEPTH) ? DONE : FILL;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = FILL;
            end
        endcase
        // Outputs registered from the next state so they align with it.
        rdy_d     = (state_d == OFFER);
        s_ready_d = (state_d == FILL);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rstmaster) begin
        if (!rstmaster) begin
            state_q   <= FILL;
            idx_q     <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            rdy_q     <= 1'b0;
            s_ready_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            rdy_q     <= rdy_d;
            s_ready_q <= s_ready_d;
            done_q    <= done_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign rdyData      = rdy_q;
    assign record_count = cnt_q;
    assign load_done    = done_q;
    assign ack_err      = err_q;

    assign data0 = data_q[0];
    assign data1 = data_q[1];
    assign data2 = data_q[2];
    assign data3 = data_q[3];
    assign data4 = data_q[4];
    assign data5 = data_q[5];
    assign data6 = data_q[6];
    assign data7 = data_q[7];

endmodule

// File: tb/tb_ode_record_loader.sv
// Directed self-checking bench for ode_record_loader.
// Runs the DUT with memory_depth=4 and ACK_TIMEOUT=16.
module tb_ode_record_loader;

    logic        clk;
    logic        rstmaster;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        rdyData;
    logic        wein;
    logic [31:0] d [8];
    logic [8:0]  record_count;
    logic        load_done;
    logic        ack_err;

    int tests;
    int failed;

    ode_record_loader #(
        .memory_depth (4),
        .ACK_TIMEOUT  (16)
    ) dut (
        .clk          (clk),
        .rstmaster    (rstmaster),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .rdyData      (rdyData),
        .wein         (wein),
        .data0        (d[0]),
        .data1        (d[1]),
        .data2        (d[2]),
        .data3        (d[3]),
        .data4        (d[4]),
        .data5        (d[5]),
        .data6        (d[6]),
        .data7        (d[7]),
        .record_count (record_count),
        .load_done    (load_done),
        .ack_err      (ack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rstmaster = 1'b0;
        s_valid   = 1'b0;
        wein      = 1'b0;
        tick();
        tick();
        rstmaster = 1'b1;
        tick();
    endtask

    // Streams eight words base+0 .. base+7 with s_valid held high.
    task automatic fill(input logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            s_data  = base + 32'(i);
            s_valid = 1'b1;
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic handshake();
        wein = 1'b1;
        tick();
        wein = 1'b0;
        tick();
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        rstmaster = 1'b0;
        s_data    = '0;
        s_valid   = 1'b0;
        wein      = 1'b0;
        #2;
        chk1("rst_s_ready", s_ready, 1'b0);
        chk1("rst_rdy", rdyData, 1'b0);
        chk32("rst_count", 32'(record_count), 32'd0);
        chk1("rst_done", load_done, 1'b0);
        chk1("rst_err", ack_err, 1'b0);
        chk32("rst_data7", d[7], 32'd0);
        tick();
        rstmaster = 1'b1;
        tick();
        chk1("fill_s_ready", s_ready, 1'b1);

        // Single record.
        for (int i = 0; i < 7; i++) begin
            s_data  = 32'(i + 1);
            s_valid = 1'b1;
            tick();
        end
        chk1("rdy_before_8th", rdyData, 1'b0);
        s_data = 32'd8;
        tick();
        s_valid = 1'b0;
        chk1("rdy_after_8th", rdyData, 1'b1);
        chk1("offer_s_ready", s_ready, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk32($sformatf("rec1_data%0d", i), d[i], 32'(i + 1));
        end
        wein = 1'b1;
        tick();
        chk1("rdy_after_rise", rdyData, 1'b0);
        tick();
        chk32("hold_data0", d[0], 32'd1);
        tick();
        chk32("hold_count", 32'(record_count), 32'd0);
        wein = 1'b0;
        tick();
        chk32("rec1_count", 32'(record_count), 32'd1);
        chk1("rec1_s_ready", s_ready, 1'b1);

        // Wein already high when the offer starts.
        do_reset();
        wein = 1'b1;
        fill(32'h11);
        chk1("lvl_rdy", rdyData, 1'b1);
        tick();
        tick();
        chk1("lvl_still_offer", rdyData, 1'b1);
        wein = 1'b0;
        tick();
        chk1("lvl_low_offer", rdyData, 1'b1);
        wein = 1'b1;
        tick();
        chk1("lvl_ack_rdy", rdyData, 1'b0);
        wein = 1'b0;
        tick();
        chk32("lvl_count", 32'(record_count), 32'd1);

        // Back-pressure during HOLD.
        fill(32'h21);
        wein = 1'b1;
        tick();
        s_data  = 32'hDEAD;
        s_valid = 1'b1;
        chk1("bp_s_ready", s_ready, 1'b0);
        tick();
        chk32("bp_data0_held", d[0], 32'h21);
        wein = 1'b0;
        tick();
        chk1("bp_s_ready_back", s_ready, 1'b1);
        chk32("bp_count", 32'(record_count), 32'd2);
        tick();
        s_valid = 1'b0;
        chk32("bp_data0_dead", d[0], 32'hDEAD);
        chk32("bp_data1_old", d[1], 32'h22);

        // Full load of four records.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            fill(32'(16 * (r + 1)));
            handshake();
        end
        chk32("full_count3", 32'(record_count), 32'd3);
        chk1("full_done3", load_done, 1'b0);
        fill(32'h40);
        handshake();
        chk32("full_count4", 32'(record_count), 32'd4);
        chk1("full_done4", load_done, 1'b1);
        chk1("full_s_ready", s_ready, 1'b0);
        s_data  = 32'h33;
        s_valid = 1'b1;
        tick();
        tick();
        s_valid = 1'b0;
        chk1("extra_s_ready", s_ready, 1'b0);
        chk32("extra_data0", d[0], 32'h40);
        chk1("extra_done", load_done, 1'b1);
        chk1("extra_rdy", rdyData, 1'b0);

        // Ack timeout.
        do_reset();
        fill(32'h50);
        for (int i = 0; i < 15; i++) tick();
        chk1("tmo_err_15", ack_err, 1'b0);
        tick();
        chk1("tmo_err_16", ack_err, 1'b1);
        chk1("tmo_rdy", rdyData, 1'b1);
        tick();
        tick();
        tick();
        chk1("tmo_rdy_late", rdyData, 1'b1);
        handshake();
        chk32("tmo_count", 32'(record_count), 32'd1);
        chk1("tmo_err_sticky", ack_err, 1'b1);

        // Reset in the middle of an offer.
        fill(32'h60);
        chk1("mid_rdy", rdyData, 1'b1);
        #2;
        rstmaster = 1'b0;
        #1;
        chk1("mid_rdy_async", rdyData, 1'b0);
        chk32("mid_data0", d[0], 32'd0);
        chk32("mid_data7", d[7], 32'd0);
        chk32("mid_count", 32'(record_count), 32'd0);
        chk1("mid_err", ack_err, 1'b0);
        tick();
        tick();
        chk1("mid_s_ready_rst", s_ready, 1'b0);
        rstmaster = 1'b1;
        tick();
        chk1("mid_s_ready", s_ready, 1'b1);
        chk1("mid_rdy_after", rdyData, 1'b0);
        s_data  = 32'h77;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk32("mid_first_word", d[0], 32'h77);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
